mold_feed_arbiter: RTL and testbench

Line arbiter for redundant NASDAQ A/B MoldUDP64 feeds. Two `eth_udp_parser` instances, one per feed, present header metadata and ITCH payload bytes. This block tracks the expected MoldUDP64 sequence number and grants the single downstream ITCH byte stream to whichever feed first delivers the next packet. Duplicates are dropped, and gaps are reported to the recovery logic. It sits between the parsers and the order-book builder on the 250 MHz domain.

---
 rtl/mold_feed_arbiter_pkg.sv | 30 +++
 rtl/mold_feed_arbiter_seq_check.sv | 26 ++
 rtl/mold_feed_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mold_feed_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mold_feed_arbiter_pkg.sv
// Shared types and constants for the MoldUDP64 A/B feed arbiter.
// Holds the sequence-number type, the arbiter state enum and the gap-length saturation value.
package mold_feed_arbiter_pkg;

    typedef logic [63:0] moldSeqType;

    typedef enum logic [2:0] {
        StIdle,
        StFwdA,
        StFwdB,
        StDropA,
        StDropB,
        StDropAb
    } arbStateType;

    localparam logic [31:0] GAP_LEN_MAX = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_gap_len(input moldSeqType diff);
        return (diff > {32'd0, GAP_LEN_MAX}) ? GAP_LEN_MAX : diff[31:0];
    endfunction

    // Ungranted state, labelled by which feeds still have a payload being discarded.
    function automatic arbStateType idle_state(input logic drop_a, input logic drop_b);
        if (drop_a && drop_b) return StDropAb;
        if (drop_a) return StDropA;
        if (drop_b) return StDropB;
        return StIdle;
    endfunction

endpackage

// File: rtl/mold_feed_arbiter_seq_check.sv
// Combinational MoldUDP64 sequence check of one header against the expected sequence number.
// Reports accept/duplicate/gap, the saturated gap length and the advanced expected number.
module mold_seq_check
    import mold_feed_arbiter_pkg::*;
(
    input  logic [63:0] i_seq,
    input  logic [15:0] i_cnt,
    input  logic [63:0] i_exp_seq,
    input  logic        i_synced,
    output logic        o_accept,
    output logic        o_dup,
    output logic        o_gap,
    output logic [31:0] o_gap_len,
    output logic [63:0] o_next_exp
);

    moldSeqType w_diff;

    assign w_diff     = i_seq - i_exp_seq;
    assign o_dup      = i_synced && (i_seq < i_exp_seq);
    assign o_accept   = !o_dup;
    assign o_gap      = i_synced && (i_seq > i_exp_seq);
    assign o_gap_len  = o_gap ? sat_gap_len(w_diff) : 32'd0;
    assign o_next_exp = i_seq + {48'd0, i_cnt};

endmodule

// File: rtl/mold_feed_arbiter.sv
// A/B MoldUDP64 line arbiter: grants the ITCH byte stream to the first feed delivering the
// next expected packet, drops duplicates/collisions and reports sequence gaps.
module mold_feed_arbiter
    import mold_feed_arbiter_pkg::*;
#(
    parameter int unsigned FIRST_SYNC = 1
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic        hdrValidAIn,
    input  logic        hdrValidBIn,
    input  logic [63:0] seqAIn,
    input  logic [63:0] seqBIn,
    input  logic [15:0] msgCntAIn,
    input  logic [15:0] msgCntBIn,
    input  logic [7:0]  dataAIn,
    input  logic [7:0]  dataBIn,
    input  logic        dataValidAIn,
    input  logic        dataValidBIn,
    output logic [7:0]  itchDataOut,
    output logic        itchDataValidOut,
    output logic        gapValidOut,
    output logic [63:0] gapStartOut,
    output logic [31:0] gapLenOut,
    output logic [31:0] dupCntOut,
    output logic [31:0] gapCntOut
);

    localparam moldSeqType EXP_RESET  = (FIRST_SYNC != 0) ? 64'd0 : 64'd1;
    localparam logic       SYNC_RESET = (FIRST_SYNC == 0);

    arbStateType r_state, w_state_next;
    moldSeqType  r_exp_seq, w_exp_mid, w_next_exp_a, w_next_exp_b;
    logic        r_synced, w_sync_mid;
    logic        r_drop_a, r_drop_b, w_drop_a_next, w_drop_b_next;
    logic        r_seen_a, r_seen_b, w_end_a, w_end_b;
    logic        w_fwd_a, w_fwd_b, w_idle, w_hdr_a, w_hdr_b;
    logic        w_acc_a, w_dup_a, w_gap_a, w_acc_b, w_dup_b, w_gap_b;
    logic [31:0] w_gap_len_a, w_gap_len_b;
    logic        w_take_a, w_take_b, w_drop_hdr_a, w_drop_hdr_b, w_gap_event;
    logic        w_out_valid;
    logic [7:0]  w_out_data;

    logic [7:0]  r_itch_data;
    logic        r_itch_valid, r_gap_valid;
    logic [63:0] r_gap_start;
    logic [31:0] r_gap_len, r_dup_cnt, r_gap_cnt;

    assign w_fwd_a = (r_state == StFwdA);
    assign w_fwd_b = (r_state == StFwdB);
    assign w_idle  = !w_fwd_a && !w_fwd_b;
    // A header on the currently granted feed is a protocol violation and is ignored.
    assign w_hdr_a = hdrValidAIn && !w_fwd_a;
    assign w_hdr_b = hdrValidBIn && !w_fwd_b;

    mold_seq_check u_chk_a (
        .i_seq      (seqAIn),
        .i_cnt      (msgCntAIn),
        .i_exp_seq  (r_exp_seq),
        .i_synced   (r_synced),
        .o_accept   (w_acc_a),
        .o_dup      (w_dup_a),
        .o_gap      (w_gap_a),
        .o_gap_len  (w_gap_len_a),
        .o_next_exp (w_next_exp_a)
    );

    assign w_take_a   = w_idle && w_hdr_a && w_acc_a;
    assign w_exp_mid  = w_take_a ? w_next_exp_a : r_exp_seq;
    assign w_sync_mid = r_synced || w_take_a;

    mold_seq_check u_chk_b (
        .i_seq      (seqBIn),
        .i_cnt      (msgCntBIn),
        .i_exp_seq  (w_exp_mid),
        .i_synced   (w_sync_mid),
        .o_accept   (w_acc_b),
        .o_dup      (w_dup_b),
        .o_gap      (w_gap_b),
        .o_gap_len  (w_gap_len_b),
        .o_next_exp (w_next_exp_b)
    );

    // B only wins when A did not take the line this cycle; otherwise it is a collision.
    assign w_take_b     = w_idle && w_hdr_b && w_acc_b && !w_take_a;
    assign w_drop_hdr_a = w_hdr_a && (w_fwd_b || w_dup_a);
    assign w_drop_hdr_b = w_hdr_b && (w_fwd_a || w_dup_b || w_take_a);
    assign w_gap_event  = (w_take_a && w_gap_a) || (w_take_b && w_gap_b);
    assign w_end_a      = r_seen_a && !dataValidAIn;
    assign w_end_b      = r_seen_b && !dataValidBIn;

    always_comb begin
        w_drop_a_next = r_drop_a;
        if (w_drop_hdr_a) begin
            w_drop_a_next = (msgCntAIn != 16'd0);
        end else if (w_take_a || w_end_a) begin
            w_drop_a_next = 1'b0;
        end
        w_drop_b_next = r_drop_b;
        if (w_drop_hdr_b) begin
            w_drop_b_next = (msgCntBIn != 16'd0);
        end else if (w_take_b || w_end_b) begin
            w_drop_b_next = 1'b0;
        end
    end

    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StFwdA: begin
                if (w_end_a) w_state_next = idle_state(w_drop_a_next, w_drop_b_next);
            end
            StFwdB: begin
                if (w_end_b) w_state_next = idle_state(w_drop_a_next, w_drop_b_next);
            end
            default: begin
                if (w_take_a && (msgCntAIn != 16'd0)) begin
                    w_state_next = StFwdA;
                end else if (w_take_b && (msgCntBIn != 16'd0)) begin
                    w_state_next = StFwdB;
                end else begin
                    w_state_next = idle_state(w_drop_a_next, w_drop_b_next);
                end
            end
        endcase
    end

    always_comb begin
        w_out_valid = 1'b0;
        w_out_data  = r_itch_data;
        if (w_fwd_a && dataValidAIn) begin
            w_out_valid = 1'b1;
            w_out_data  = dataAIn;
        end else if (w_fwd_b && dataValidBIn) begin
            w_out_valid = 1'b1;
            w_out_data  = dataBIn;
        end
    end

    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            r_exp_seq    <= EXP_RESET;
            r_synced     <= SYNC_RESET;
            r_drop_a     <= 1'b0;
            r_drop_b     <= 1'b0;
            r_seen_a     <= 1'b0;
            r_seen_b     <= 1'b0;
            r_itch_data  <= 8'd0;
            r_itch_valid <= 1'b0;
            r_gap_valid  <= 1'b0;
            r_gap_start  <= 64'd0;
            r_gap_len    <= 32'd0;
            r_dup_cnt    <= 32'd0;
            r_gap_cnt    <= 32'd0;
        end else begin
            r_exp_seq    <= w_take_b ? w_next_exp_b : w_exp_mid;
            r_synced     <= w_sync_mid || w_take_b;
            r_drop_a     <= w_drop_a_next;
            r_drop_b     <= w_drop_b_next;
            r_seen_a     <= dataValidAIn && !w_hdr_a;
            r_seen_b     <= dataValidBIn && !w_hdr_b;
            r_itch_data  <= w_out_data;
            r_itch_valid <= w_out_valid;
            r_gap_valid  <= w_gap_event;
            if (w_gap_event) begin
                r_gap_start <= r_exp_seq;
                r_gap_len   <= w_take_a ? w_gap_len_a : w_gap_len_b;
            end
            r_dup_cnt <= r_dup_cnt + 32'(w_drop_hdr_a) + 32'(w_drop_hdr_b);
            r_gap_cnt <= r_gap_cnt + 32'(w_gap_event);
        end
    end

    assign itchDataOut      = r_itch_data;
    assign itchDataValidOut = r_itch_valid;
    assign gapValidOut      = r_gap_valid;
    assign gapStartOut      = r_gap_start;
    assign gapLenOut        = r_gap_len;
    assign dupCntOut        = r_dup_cnt;
    assign gapCntOut        = r_gap_cnt;

endmodule

// File: tb/tb_mold_feed_arbiter.sv
// Directed bench for mold_feed_arbiter: a packet-level reference model is compared with the
// DUT on every negedge, and hand-computed literals pin the key scenarios.
module tb_mold_feed_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        hva, hvb, dva, dvb;
    logic [63:0] sqa, sqb;
    logic [15:0] cna, cnb;
    logic [7:0]  da, db;
    logic [7:0]  itchDataOut;
    logic        itchDataValidOut, gapValidOut;
    logic [63:0] gapStartOut;
    logic [31:0] gapLenOut, dupCntOut, gapCntOut;

    int n_checks = 0;
    int n_errors = 0;
    int n_bytes_out = 0;
    int b0;
    bit model_ready = 0;

    // Reference model state and expected registered outputs.
    logic [63:0] m_exp;
    bit          m_synced, m_seen;
    int          m_grant;
    logic [31:0] m_dup, m_gapcnt;
    bit          e_valid, e_gap;
    logic [7:0]  e_data;
    logic [63:0] e_gstart;
    logic [31:0] e_glen;

    always #2 clk = ~clk;

    mold_feed_arbiter #(.FIRST_SYNC(1)) dut (
        .clkIn            (clk),
        .rstIn            (rst),
        .hdrValidAIn      (hva),
        .hdrValidBIn      (hvb),
        .seqAIn           (sqa),
        .seqBIn           (sqb),
        .msgCntAIn        (cna),
        .msgCntBIn        (cnb),
        .dataAIn          (da),
        .dataBIn          (db),
        .dataValidAIn     (dva),
        .dataValidBIn     (dvb),
        .itchDataOut      (itchDataOut),
        .itchDataValidOut (itchDataValidOut),
        .gapValidOut      (gapValidOut),
        .gapStartOut      (gapStartOut),
        .gapLenOut        (gapLenOut),
        .dupCntOut        (dupCntOut),
        .gapCntOut        (gapCntOut)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic take(input logic [63:0] s, input logic [15:0] c, input int feed);
        logic [63:0] diff;
        if (m_synced && s > m_exp) begin
            e_gap    = 1;
            e_gstart = m_exp;
            diff     = s - m_exp;
            e_glen   = (diff > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : diff[31:0];
            m_gapcnt++;
        end
        m_synced = 1;
        m_exp    = s + 64'(c);
        if (c != 16'd0) begin
            m_grant = feed;
            m_seen  = 0;
        end
    endtask

    task automatic model_eval();
        int g;
        bit a_take;
        if (!rst) begin
            m_exp = 64'd0; m_synced = 0; m_grant = 0; m_seen = 0;
            m_dup = 32'd0; m_gapcnt = 32'd0;
            e_valid = 0; e_gap = 0; e_data = 8'd0; e_gstart = 64'd0; e_glen = 32'd0;
        end else begin
            g = m_grant;
            e_valid = 0;
            e_gap = 0;
            if (g == 1) begin
                if (dva) begin e_valid = 1; e_data = da; m_seen = 1; end
                else if (m_seen) m_grant = 0;
            end
            if (g == 2) begin
                if (dvb) begin e_valid = 1; e_data = db; m_seen = 1; end
                else if (m_seen) m_grant = 0;
            end
            a_take = 0;
            if (g == 0) begin
                if (hva) begin
                    if (!m_synced || sqa >= m_exp) begin
                        a_take = 1;
                        take(sqa, cna, 1);
                    end else m_dup++;
                end
                if (hvb) begin
                    if (!a_take && (!m_synced || sqb >= m_exp)) take(sqb, cnb, 2);
                    else m_dup++;
                end
            end else begin
                if (hva && g == 2) m_dup++;
                if (hvb && g == 1) m_dup++;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (model_ready) begin
                chk("itch_valid", itchDataValidOut, e_valid);
                if (e_valid) chk("itch_data", itchDataOut, e_data);
                chk("gap_valid", gapValidOut, e_gap);
                chk("gap_start", gapStartOut, e_gstart);
                chk("gap_len", gapLenOut, e_glen);
                chk("dup_cnt", dupCntOut, m_dup);
                chk("gap_cnt", gapCntOut, m_gapcnt);
                if (itchDataValidOut) n_bytes_out++;
            end
            model_eval();
            model_ready = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        hva = 1'b0; hvb = 1'b0; dva = 1'b0; dvb = 1'b0;
        sqa = 64'd0; sqb = 64'd0; cna = 16'd0; cnb = 16'd0; da = 8'd0; db = 8'd0;
    endtask

    task automatic idle(input int n);
        clr();
        repeat (n) tick();
    endtask

    task automatic pkt(input bit feed_b, input logic [63:0] s, input logic [15:0] c,
                       input int n, input logic [7:0] base);
        clr();
        if (feed_b) begin hvb = 1'b1; sqb = s; cnb = c; end
        else begin hva = 1'b1; sqa = s; cna = c; end
        tick();
        idle(1);
        for (int i = 0; i < n; i++) begin
            clr();
            if (feed_b) begin dvb = 1'b1; db = base + 8'(i); end
            else begin dva = 1'b1; da = base + 8'(i); end
            tick();
        end
        idle(2);
    endtask

    initial begin
        rst = 1'b0;
        clr();
        repeat (3) tick();
        chk("reset_valid", itchDataValidOut, 64'd0);
        chk("reset_dup", dupCntOut, 64'd0);
        chk("reset_gapcnt", gapCntOut, 64'd0);
        chk("reset_gapstart", gapStartOut, 64'd0);
        rst = 1'b1;
        idle(2);

        // In-order A: seq 1, seq 2, 36 bytes each.
        b0 = n_bytes_out;
        pkt(1'b0, 64'd1, 16'd1, 36, 8'h10);
        pkt(1'b0, 64'd2, 16'd1, 36, 8'h40);
        chk("inorder_bytes", 64'(n_bytes_out - b0), 64'd72);
        chk("inorder_gapcnt", gapCntOut, 64'd0);
        chk("inorder_dup", dupCntOut, 64'd0);

        // seq 3 must be next in line (no gap), two messages -> expected becomes 5.
        pkt(1'b0, 64'd3, 16'd2, 4, 8'h80);
        chk("seq3_gapcnt", gapCntOut, 64'd0);

        // A seq 5, then B seq 5 three cycles later.
        b0 = n_bytes_out;
        clr(); hva = 1'b1; sqa = 64'd5; cna = 16'd1; tick();
        idle(1);
        for (int i = 0; i < 18; i++) begin
            clr();
            dva = (i < 16); da = 8'hA0 + 8'(i);
            hvb = (i == 1); sqb = 64'd5; cnb = 16'd1;
            dvb = (i >= 2); db = 8'hC0 + 8'(i);
            tick();
        end
        idle(3);
        chk("dup_cnt_ab", dupCntOut, 64'd1);
        chk("dup_bytes", 64'(n_bytes_out - b0), 64'd16);

        // Simultaneous headers, seq 6 on both feeds.
        clr(); hva = 1'b1; hvb = 1'b1; sqa = 64'd6; sqb = 64'd6; cna = 16'd1; cnb = 16'd1;
        tick();
        idle(1);
        for (int i = 0; i < 10; i++) begin
            clr(); dva = 1'b1; dvb = 1'b1; da = 8'h20 + 8'(i); db = 8'hE0 + 8'(i);
            tick();
        end
        idle(3);
        chk("collision_dup", dupCntOut, 64'd2);

        // Gap: expected 7, A seq 9.
        clr(); hva = 1'b1; sqa = 64'd9; cna = 16'd1; tick();
        chk("gap_pulse", gapValidOut, 64'd1);
        chk("gap_start_lit", gapStartOut, 64'd7);
        chk("gap_len_lit", gapLenOut, 64'd2);
        chk("gap_cnt_lit", gapCntOut, 64'd1);
        idle(1);
        chk("gap_pulse_one", gapValidOut, 64'd0);
        for (int i = 0; i < 5; i++) begin
            clr(); dva = 1'b1; da = 8'h50 + 8'(i); tick();
        end
        idle(2);

        // Heartbeat far ahead: gap length saturates, nothing forwarded.
        clr(); hva = 1'b1; sqa = 64'd10 + (64'd1 << 40); cna = 16'd0; tick();
        chk("sat_gap_len", gapLenOut, 64'hFFFF_FFFF);
        chk("sat_gap_start", gapStartOut, 64'd10);
        idle(2);

        // Wrap: seq all-ones, one message -> expected 0; then heartbeat seq 0.
        pkt(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 16'd1, 4, 8'h60);
        chk("wrap_gapcnt", gapCntOut, 64'd3);
        clr(); hva = 1'b1; sqa = 64'd0; cna = 16'd0; tick();
        chk("hb_no_gap", gapValidOut, 64'd0);
        idle(2);
        chk("hb_no_valid", itchDataValidOut, 64'd0);
        pkt(1'b0, 64'd0, 16'd1, 3, 8'h70);
        chk("after_hb_dup", dupCntOut, 64'd2);
        chk("after_hb_gapcnt", gapCntOut, 64'd3);

        // Reset in the middle of a payload, then re-sync.
        clr(); hva = 1'b1; sqa = 64'd1; cna = 16'd1; tick();
        idle(1);
        for (int i = 0; i < 20; i++) begin
            clr(); dva = 1'b1; da = 8'h30 + 8'(i);
            rst = (i != 10);
            tick();
            if (i == 10) begin
                chk("rst_valid", itchDataValidOut, 64'd0);
                chk("rst_dup", dupCntOut, 64'd0);
                chk("rst_gapcnt", gapCntOut, 64'd0);
            end
        end
        rst = 1'b1;
        idle(2);
        b0 = n_bytes_out;
        pkt(1'b0, 64'd1, 16'd1, 5, 8'h90);
        chk("resync_bytes", 64'(n_bytes_out - b0), 64'd5);
        chk("resync_gapcnt", gapCntOut, 64'd0);

        // B-only packet, then A duplicate alongside an acceptable B.
        pkt(1'b1, 64'd2, 16'd1, 6, 8'hB0);
        clr(); hva = 1'b1; hvb = 1'b1; sqa = 64'd1; sqb = 64'd3; cna = 16'd1; cnb = 16'd1;
        tick();
        idle(1);
        b0 = n_bytes_out;
        for (int i = 0; i < 6; i++) begin
            clr(); dva = 1'b1; dvb = 1'b1; da = 8'h00 + 8'(i); db = 8'hF0 + 8'(i);
            tick();
        end
        idle(3);
        chk("b_wins_bytes", 64'(n_bytes_out - b0), 64'd6);
        chk("b_wins_dup", dupCntOut, 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
